drawbridge_seq_ctrl: RTL and testbench

//   Parametrised successor of the fixed bridge-control benchmark FSM.

---
 rtl/drawbridge_pkg.sv | 64 ++++++
 rtl/dwell_timer.sv | 21 ++
 rtl/drawbridge_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_drawbridge_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/drawbridge_pkg.sv
// Shared state encoding and Moore output decode for the drawbridge sequencer.
// Pure declarations: no latency, no flow control.
package drawbridge_pkg;

    localparam int GATE_MAX = 16;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WARN     = 3'd1,
        S_GATES_DN = 3'd2,
        S_RAISE    = 3'd3,
        S_OPEN     = 3'd4,
        S_LOWER    = 3'd5,
        S_GATES_UP = 3'd6,
        S_FAULT    = 3'd7
    } state_t;

    typedef struct packed {
        logic road_go;
        logic warn_light;
        logic gates_lower;
        logic motor_up;
        logic motor_dn;
        logic vessel_go;
        logic fault;
    } drive_t;

    // Each motor is driven from exactly one state, so up/down can never overlap.
    function automatic drive_t decode_drive(state_t s);
        drive_t d;
        d = '0;
        case (s)
            S_IDLE:     d.road_go = 1'b1;
            S_WARN:     d.warn_light = 1'b1;
            S_GATES_DN: begin
                d.warn_light  = 1'b1;
                d.gates_lower = 1'b1;
            end
            S_RAISE: begin
                d.warn_light  = 1'b1;
                d.gates_lower = 1'b1;
                d.motor_up    = 1'b1;
            end
            S_OPEN: begin
                d.gates_lower = 1'b1;
                d.vessel_go   = 1'b1;
            end
            S_LOWER: begin
                d.warn_light  = 1'b1;
                d.gates_lower = 1'b1;
                d.motor_dn    = 1'b1;
            end
            S_GATES_UP: d.warn_light = 1'b1;
            S_FAULT: begin
                d.fault       = 1'b1;
                d.warn_light  = 1'b1;
                d.gates_lower = 1'b1;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Saturating dwell counter; clr wins over en, count updates one cycle after inputs.
// No flow control: counts every enabled cycle and sticks at all-ones.
module dwell_timer #(
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [TW-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != {TW{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/drawbridge_seq_ctrl.sv
// Bridge sequencer: warning, barriers, deck motion, timed open hold, motor-timeout fault.
// Moore outputs follow the registered state one cycle after a transition; no backpressure.
module drawbridge_seq_ctrl #(
    parameter int N_GATES    = 4,
    parameter int TW         = 16,
    parameter int WARN_CYC   = 8,
    parameter int MOTOR_TO   = 64,
    parameter int HOLD_CYC   = 32,
    parameter bit AUTO_CLOSE = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_open,
    input  logic               req_close,
    input  logic               obstruct,
    input  logic               vessel_present,
    input  logic [N_GATES-1:0] gate_down,
    input  logic               deck_up,
    input  logic               deck_down,
    input  logic               fault_clr,
    output logic               road_go,
    output logic               warn_light,
    output logic [N_GATES-1:0] gate_cmd,
    output logic               motor_up,
    output logic               motor_dn,
    output logic               vessel_go,
    output logic               fault,
    output logic [2:0]         state_o
);
    import drawbridge_pkg::*;

    if (N_GATES < 1 || N_GATES > GATE_MAX) begin : g_bad_gates
        $error("drawbridge_seq_ctrl: N_GATES out of range");
    end
    if (WARN_CYC < 1 || HOLD_CYC < 1 || MOTOR_TO < 2) begin : g_bad_min
        $error("drawbridge_seq_ctrl: cycle parameter below minimum");
    end
    if (longint'(WARN_CYC) > (64'd1 << TW) || longint'(MOTOR_TO) > (64'd1 << TW) ||
        longint'(HOLD_CYC) > (64'd1 << TW)) begin : g_bad_tw
        $error("drawbridge_seq_ctrl: cycle parameter exceeds timer range");
    end

    localparam logic [TW-1:0] WARN_LIM  = TW'(WARN_CYC - 1);
    localparam logic [TW-1:0] MOTOR_LIM = TW'(MOTOR_TO - 1);
    localparam logic [TW-1:0] HOLD_LIM  = TW'(HOLD_CYC - 1);

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic          timer_clr;
    logic          timed_out;
    logic          deck_conflict;
    drive_t        drv;

    dwell_timer #(.TW(TW)) u_dwell (
        .clk   (clk),
        .rst   (rst),
        .clr   (timer_clr),
        .en    (1'b1),
        .count (timer)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign timed_out     = (timer == MOTOR_LIM);
    assign deck_conflict = deck_up && deck_down;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_open && !obstruct) state_nxt = S_WARN;
            end
            S_WARN: begin
                if (obstruct)                  state_nxt = S_IDLE;
                else if (timer == WARN_LIM)    state_nxt = S_GATES_DN;
            end
            S_GATES_DN: begin
                if (&gate_down)                state_nxt = S_RAISE;
                else if (timed_out)            state_nxt = S_FAULT;
            end
            S_RAISE: begin
                if (deck_conflict)             state_nxt = S_FAULT;
                else if (deck_up)              state_nxt = S_OPEN;
                else if (timed_out)            state_nxt = S_FAULT;
            end
            S_OPEN: begin
                if (req_close || (AUTO_CLOSE && (timer == HOLD_LIM) && !vessel_present))
                    state_nxt = S_LOWER;
            end
            S_LOWER: begin
                if (deck_conflict)             state_nxt = S_FAULT;
                else if (deck_down)            state_nxt = S_GATES_UP;
                else if (timed_out)            state_nxt = S_FAULT;
            end
            S_GATES_UP: begin
                if (~|gate_down)               state_nxt = S_IDLE;
                else if (timed_out)            state_nxt = S_FAULT;
            end
            S_FAULT: begin
                if (fault_clr)                 state_nxt = deck_down ? S_GATES_UP : S_LOWER;
            end
            default:                           state_nxt = S_IDLE;
        endcase
    end

    // A vessel in the channel restarts the open hold so auto-close waits for a clear channel.
    assign timer_clr = (state_nxt != state) || ((state == S_OPEN) && vessel_present);

    assign drv        = decode_drive(state);
    assign road_go    = drv.road_go;
    assign warn_light = drv.warn_light;
    assign gate_cmd   = {N_GATES{drv.gates_lower}};
    assign motor_up   = drv.motor_up;
    assign motor_dn   = drv.motor_dn;
    assign vessel_go  = drv.vessel_go;
    assign fault      = drv.fault;
    assign state_o    = state;

endmodule

// File: tb/tb_drawbridge_seq_ctrl.sv
// Directed bench: default-parameter sequencer plus an AUTO_CLOSE=0 instance on shared inputs.
module tb_drawbridge_seq_ctrl;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_WARN = 3'd1, ST_GDN = 3'd2, ST_RAISE = 3'd3;
    localparam logic [2:0] ST_OPEN = 3'd4, ST_LOWER = 3'd5, ST_GUP = 3'd6, ST_FAULT = 3'd7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_b = 1'b1;
    logic       req_open = 1'b0, req_close = 1'b0, obstruct = 1'b0, vessel_present = 1'b0;
    logic [3:0] gate_down = 4'h0;
    logic       deck_up = 1'b0, deck_down = 1'b1, fault_clr = 1'b0;

    logic       road_go, warn_light, motor_up, motor_dn, vessel_go, fault;
    logic [3:0] gate_cmd;
    logic [2:0] state_o;
    logic       road_go_b, warn_light_b, motor_up_b, motor_dn_b, vessel_go_b, fault_b;
    logic [3:0] gate_cmd_b;
    logic [2:0] state_o_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    drawbridge_seq_ctrl dut (
        .clk(clk), .rst(rst), .req_open(req_open), .req_close(req_close),
        .obstruct(obstruct), .vessel_present(vessel_present), .gate_down(gate_down),
        .deck_up(deck_up), .deck_down(deck_down), .fault_clr(fault_clr),
        .road_go(road_go), .warn_light(warn_light), .gate_cmd(gate_cmd),
        .motor_up(motor_up), .motor_dn(motor_dn), .vessel_go(vessel_go),
        .fault(fault), .state_o(state_o)
    );

    drawbridge_seq_ctrl #(.AUTO_CLOSE(1'b0)) dut_b (
        .clk(clk), .rst(rst_b), .req_open(req_open), .req_close(req_close),
        .obstruct(obstruct), .vessel_present(vessel_present), .gate_down(gate_down),
        .deck_up(deck_up), .deck_down(deck_down), .fault_clr(fault_clr),
        .road_go(road_go_b), .warn_light(warn_light_b), .gate_cmd(gate_cmd_b),
        .motor_up(motor_up_b), .motor_dn(motor_dn_b), .vessel_go(vessel_go_b),
        .fault(fault_b), .state_o(state_o_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // IDLE -> WARN -> GATES_DN -> RAISE -> OPEN with immediate sensor acks.
    task automatic reach_open();
        req_open = 1'b1;
        tick();
        req_open = 1'b0;
        ticks(8);
        gate_down = 4'hF;
        deck_down = 1'b0;
        tick();
        deck_up = 1'b1;
        tick();
    endtask

    initial begin
        // Reset values
        ticks(2);
        chk("rst_state", state_o, ST_IDLE);
        chk("rst_road_go", road_go, 1'b1);
        chk("rst_warn", warn_light, 1'b0);
        chk("rst_gate_cmd", gate_cmd, 4'h0);
        chk("rst_motors", {motor_up, motor_dn}, 2'b00);
        chk("rst_vessel_fault", {vessel_go, fault}, 2'b00);
        rst = 1'b0;
        tick();
        chk("idle_hold", state_o, ST_IDLE);

        // 1. Full cycle with auto-close
        req_open = 1'b1;
        tick();
        chk("t1_warn", state_o, ST_WARN);
        chk("t1_warn_light", warn_light, 1'b1);
        chk("t1_road_stop", road_go, 1'b0);
        req_open = 1'b0;
        ticks(7);
        chk("t1_warn_last", state_o, ST_WARN);
        tick();
        chk("t1_gdn", state_o, ST_GDN);
        chk("t1_gdn_cmd", gate_cmd, 4'hF);
        ticks(2);
        chk("t1_gdn_wait", state_o, ST_GDN);
        gate_down = 4'hF;
        deck_down = 1'b0;
        tick();
        chk("t1_raise", state_o, ST_RAISE);
        chk("t1_raise_motors", {motor_up, motor_dn}, 2'b10);
        ticks(9);
        chk("t1_raise_wait", state_o, ST_RAISE);
        deck_up = 1'b1;
        tick();
        chk("t1_open", state_o, ST_OPEN);
        chk("t1_open_vgo", vessel_go, 1'b1);
        chk("t1_open_motors", {motor_up, motor_dn, warn_light}, 3'b000);
        ticks(31);
        chk("t1_open_hold", state_o, ST_OPEN);
        tick();
        chk("t1_auto_lower", state_o, ST_LOWER);
        chk("t1_lower_motors", {motor_up, motor_dn, vessel_go}, 3'b010);
        deck_up = 1'b0;
        ticks(4);
        chk("t1_lower_wait", state_o, ST_LOWER);
        deck_down = 1'b1;
        tick();
        chk("t1_gup", state_o, ST_GUP);
        chk("t1_gup_cmd", {warn_light, gate_cmd}, 5'h10);
        gate_down = 4'h0;
        tick();
        chk("t1_idle", state_o, ST_IDLE);
        chk("t1_idle_outs", {road_go, warn_light}, 2'b10);

        // 2. IDLE ignores close and blocked opens; obstruct aborts WARN
        req_close = 1'b1;
        tick();
        chk("t2_close_ignored", state_o, ST_IDLE);
        req_close = 1'b0;
        obstruct = 1'b1;
        req_open = 1'b1;
        tick();
        chk("t2_open_blocked", state_o, ST_IDLE);
        obstruct = 1'b0;
        tick();
        chk("t2_warn", state_o, ST_WARN);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_warn_no_gate", gate_cmd, 4'h0);
        end
        obstruct = 1'b1;
        req_open = 1'b0;
        tick();
        chk("t2_abort_idle", state_o, ST_IDLE);
        chk("t2_abort_gate", gate_cmd, 4'h0);
        obstruct = 1'b0;

        // 3. Stuck barrier times out into FAULT, cleared with deck down
        req_open = 1'b1;
        tick();
        req_open = 1'b0;
        ticks(8);
        chk("t3_gdn", state_o, ST_GDN);
        gate_down = 4'b1011;
        ticks(63);
        chk("t3_gdn_last", state_o, ST_GDN);
        tick();
        chk("t3_fault", state_o, ST_FAULT);
        chk("t3_fault_outs", {fault, warn_light, gate_cmd, motor_up, motor_dn, road_go},
            9'b1_1_1111_0_0_0);
        tick();
        chk("t3_fault_held", state_o, ST_FAULT);
        fault_clr = 1'b1;
        tick();
        chk("t3_clr_gup", state_o, ST_GUP);
        chk("t3_clr_fault", fault, 1'b0);
        fault_clr = 1'b0;
        gate_down = 4'h0;
        tick();
        chk("t3_idle", state_o, ST_IDLE);

        // 4. Vessel pulses hold OPEN, then auto-close after a clear hold
        reach_open();
        chk("t4_open", state_o, ST_OPEN);
        for (int p = 0; p < 3; p++) begin
            ticks(19);
            vessel_present = 1'b1;
            tick();
            vessel_present = 1'b0;
            chk("t4_open_held", state_o, ST_OPEN);
        end
        ticks(31);
        chk("t4_hold_last", state_o, ST_OPEN);
        tick();
        chk("t4_auto_lower", state_o, ST_LOWER);
        deck_up = 1'b0;
        deck_down = 1'b1;
        tick();
        chk("t4_gup", state_o, ST_GUP);
        gate_down = 4'h0;
        tick();
        chk("t4_idle", state_o, ST_IDLE);

        // 4b/6. req_close forces LOWER despite a vessel; reset mid-lower
        reach_open();
        chk("t6_open", state_o, ST_OPEN);
        vessel_present = 1'b1;
        req_close = 1'b1;
        tick();
        chk("t6_close_lower", state_o, ST_LOWER);
        chk("t6_motor_dn", motor_dn, 1'b1);
        req_close = 1'b0;
        vessel_present = 1'b0;
        rst = 1'b1;
        tick();
        chk("t6_rst_idle", state_o, ST_IDLE);
        chk("t6_rst_outs", {road_go, motor_dn, motor_up, warn_light, gate_cmd}, 8'b1000_0000);
        rst = 1'b0;
        gate_down = 4'h0;
        deck_up = 1'b0;
        deck_down = 1'b1;

        // 5. Deck sensor conflict in RAISE, then retry lower
        req_open = 1'b1;
        tick();
        req_open = 1'b0;
        ticks(8);
        gate_down = 4'hF;
        deck_down = 1'b0;
        tick();
        chk("t5_raise", state_o, ST_RAISE);
        deck_up = 1'b1;
        deck_down = 1'b1;
        tick();
        chk("t5_conflict_fault", state_o, ST_FAULT);
        chk("t5_motor_up_off", {motor_up, fault}, 2'b01);
        deck_up = 1'b0;
        deck_down = 1'b0;
        fault_clr = 1'b1;
        tick();
        chk("t5_retry_lower", state_o, ST_LOWER);
        chk("t5_retry_motor", motor_dn, 1'b1);
        fault_clr = 1'b0;
        deck_down = 1'b1;
        tick();
        chk("t5_gup", state_o, ST_GUP);
        gate_down = 4'h0;
        tick();
        chk("t5_idle", state_o, ST_IDLE);

        // 6b. AUTO_CLOSE=0 instance holds OPEN until req_close
        rst = 1'b1;
        rst_b = 1'b0;
        tick();
        chk("t6b_idle", state_o_b, ST_IDLE);
        chk("t6b_road_go", road_go_b, 1'b1);
        reach_open();
        chk("t6b_open", state_o_b, ST_OPEN);
        for (int i = 0; i < 200; i++) begin
            tick();
            chk("t6b_open_held", state_o_b, ST_OPEN);
        end
        req_close = 1'b1;
        tick();
        chk("t6b_lower", state_o_b, ST_LOWER);
        chk("t6b_motors", {motor_up_b, motor_dn_b, vessel_go_b, fault_b}, 4'b0100);
        req_close = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
